// File: rtl/writeback_merge.sv
// Writeback merge: per-source one-entry holding slots, round-robin drain,
// load-data extraction/extension and a registered register-file write port.
module writeback_merge #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned OFF_W   = $clog2(XLEN/8)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_SRC-1:0]             src_valid_i,
  output logic [NUM_SRC-1:0]             src_ready_o,
  input  logic [NUM_SRC-1:0][4:0]        src_rd_addr_i,
  input  logic [NUM_SRC-1:0][XLEN-1:0]   src_data_i,
  input  logic [NUM_SRC-1:0]             src_is_load_i,
  input  logic [NUM_SRC-1:0][1:0]        src_ld_size_i,
  input  logic [NUM_SRC-1:0]             src_ld_unsigned_i,
  input  logic [NUM_SRC-1:0][OFF_W-1:0]  src_ld_offset_i,
  output logic [4:0]                     rd_addr_W,
  output logic [XLEN-1:0]                rd_data_W,
  output logic                           rd_wr_W,
  output logic                           pending_o
);
  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef struct packed {
    logic [4:0]       rd;
    logic [XLEN-1:0]  data;
    logic             is_load;
    logic [1:0]       size;
    logic             uns;
    logic [OFF_W-1:0] off;
  } slot_t;

  slot_t [NUM_SRC-1:0]     slot_q, slot_d;
  logic  [NUM_SRC-1:0]     occ_q, occ_d;
  logic  [NUM_SRC-1:0]     grant, accept;
  logic  [PTR_W-1:0]       ptr_q, ptr_d;
  logic  [2*NUM_SRC-1:0]   occ_rot;
  logic                    gnt_vld;
  logic  [PTR_W-1:0]       gnt_idx;
  int unsigned             gnt_pos;
  slot_t                   gnt_slot;
  logic  [XLEN-1:0]        sh, mask, topbit, fmt_data;
  logic  [6:0]             width;
  logic                    sgn;
  logic  [4:0]             rd_addr_q, rd_addr_d;
  logic  [XLEN-1:0]        rd_data_q, rd_data_d;
  logic                    rd_wr_q, rd_wr_d;

  // Ready depends only on slot state, so a source can never deadlock on it.
  assign src_ready_o = {NUM_SRC{rst_ni}} & (~occ_q | grant);
  assign accept      = src_valid_i & src_ready_o;
  assign pending_o   = |occ_q;
  assign rd_addr_W   = rd_addr_q;
  assign rd_data_W   = rd_data_q;
  assign rd_wr_W     = rd_wr_q;

  // Round-robin: rotate occupancy so the pointer slot sits at bit 0.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_pos = 0;
    occ_rot = {occ_q, occ_q} >> ptr_q;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!gnt_vld && occ_rot[k]) begin
        gnt_vld = 1'b1;
        gnt_pos = 32'(ptr_q) + k;
        if (gnt_pos >= NUM_SRC) gnt_pos = gnt_pos - NUM_SRC;
        gnt_idx = PTR_W'(gnt_pos);
      end
    end
    grant = '0;
    if (gnt_vld) grant[gnt_idx] = 1'b1;
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (32'(gnt_idx) == NUM_SRC - 1) ? '0 : gnt_idx + PTR_W'(1);
    gnt_slot = slot_q[gnt_idx];
  end

  // Load formatting; an item at least XLEN wide yields an all-ones mask.
  always_comb begin
    sh       = gnt_slot.data >> {gnt_slot.off, 3'b000};
    width    = 7'd8 << gnt_slot.size;
    mask     = ~({XLEN{1'b1}} << width);
    topbit   = mask & ~(mask >> 1);
    sgn      = |(sh & topbit);
    fmt_data = gnt_slot.data;
    if (gnt_slot.is_load) begin
      fmt_data = (sh & mask) | ((sgn && !gnt_slot.uns) ? ~mask : '0);
    end
  end

  always_comb begin
    occ_d  = (occ_q & ~grant) | accept;
    slot_d = slot_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        slot_d[i].rd      = src_rd_addr_i[i];
        slot_d[i].data    = src_data_i[i];
        slot_d[i].is_load = src_is_load_i[i];
        slot_d[i].size    = src_ld_size_i[i];
        slot_d[i].uns     = src_ld_unsigned_i[i];
        slot_d[i].off     = src_ld_offset_i[i];
      end
    end
  end

  // x0 writes still drain the slot but present an all-zero, disabled write.
  always_comb begin
    rd_wr_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (gnt_vld) begin
      if (gnt_slot.rd == 5'd0) begin
        rd_addr_d = '0;
        rd_data_d = '0;
      end else begin
        rd_wr_d   = 1'b1;
        rd_addr_d = gnt_slot.rd;
        rd_data_d = fmt_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q     <= '0;
      slot_q    <= '0;
      ptr_q     <= '0;
      rd_wr_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      occ_q     <= occ_d;
      slot_q    <= slot_d;
      ptr_q     <= ptr_d;
      rd_wr_q   <= rd_wr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule
